// File: rtl/modbus_frame_check_module_pkg.sv
// Shared definitions for the Modbus 7-byte frame checker: CRC constants,
// FSM state encoding, error-code bit positions and frame byte indices.
package modbus_pkg;

  // CRC-16/Modbus parameters (reflected form, LSB-first shifting)
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Number of payload bits fed through the CRC (bytes 0..4), last index
  localparam logic [5:0] CRC_LAST_BIT = 6'd39;

  // Checker FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CRC    = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // Err_Code bit positions
  localparam int ERR_CRC_BIT  = 0;
  localparam int ERR_ADDR_BIT = 1;

  // Byte positions inside the 56-bit frame (byte0 sits in [55:48])
  localparam int BYTE_ADDR   = 0;
  localparam int BYTE_FUNC   = 1;
  localparam int BYTE_PL0    = 2;
  localparam int BYTE_CRC_LO = 5;
  localparam int BYTE_CRC_HI = 6;

  // Extract byte 'idx' of a frame, byte0 being the most significant
  function automatic logic [7:0] frame_byte(input logic [55:0] frame, input int idx);
    frame_byte = frame[(6 - idx) * 8 +: 8];
  endfunction

  // One bit-serial CRC-16/Modbus step
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = crc[0] ^ d;
    crc16_step = fb ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
  endfunction

endpackage

// File: rtl/modbus_frame_check_module_crc16.sv
// Bit-serial CRC-16/Modbus register: cleared to the init value, then
// advanced by one data bit per valid cycle.
module crc16_serial_module
  import modbus_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_clear,
  input  logic        i_bit_vld,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // CRC register: reset/clear to init, shift one bit when valid
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_crc <= CRC_INIT;
    end else if (i_clear) begin
      r_crc <= CRC_INIT;
    end else if (i_bit_vld) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/modbus_frame_check_module.sv
// Modbus 7-byte frame checker: latches a frame from the UART receiver,
// runs CRC-16/Modbus over bytes 0..4 one bit per cycle, checks the CRC
// and the slave address, then reports the result for one cycle.
module modbus_frame_check_module
  import modbus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_Done_Sig,
  input  logic [55:0] RX_Data,
  output logic        RX_En_Sig,
  output logic        Busy_Sig,
  output logic        Done_Sig,
  output logic        Frame_OK,
  output logic [1:0]  Err_Code,
  output logic [7:0]  Func_Code,
  output logic [23:0] Payload,
  output logic [7:0]  Err_Cnt
);

  state_t      r_state;
  state_t      w_next_state;
  logic [55:0] r_frame;
  logic [5:0]  r_bit_cnt;
  logic        r_crc_ok;
  logic        r_addr_ok;

  logic        w_clear;
  logic        w_bit_vld;
  logic        w_bit;
  logic [5:0]  w_bit_idx;
  logic [15:0] w_crc;
  logic [1:0]  w_err_code;
  logic [7:0]  w_addr_byte;

  logic        r_rx_en;
  logic        r_busy;
  logic        r_done;
  logic        r_frame_ok;
  logic [1:0]  r_err_code;
  logic [7:0]  r_func_code;
  logic [23:0] r_payload;
  logic [7:0]  r_err_cnt;

  // Byte b, bit k of the frame lives at index (6-b)*8 + k
  assign w_bit_idx   = {3'd6 - r_bit_cnt[5:3], r_bit_cnt[2:0]};
  assign w_bit       = r_frame[w_bit_idx];
  assign w_addr_byte = frame_byte(r_frame, BYTE_ADDR);

  crc16_serial_module u_crc (
    .CLK       (CLK),
    .RST       (RST),
    .i_clear   (w_clear),
    .i_bit_vld (w_bit_vld),
    .i_bit     (w_bit),
    .o_crc     (w_crc)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and CRC engine control
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_bit_vld    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (RX_Done_Sig) begin
          w_next_state = ST_CRC;
          w_clear      = 1'b1;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_CRC: begin
        w_bit_vld = 1'b1;
        if (r_bit_cnt == CRC_LAST_BIT) begin
          w_next_state = ST_CHECK;
        end else begin
          w_next_state = ST_CRC;
        end
      end
      ST_CHECK: begin
        w_next_state = ST_REPORT;
      end
      ST_REPORT: begin
        w_next_state = ST_WAIT;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Frame latch and non-wrapping bit counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame   <= 56'd0;
      r_bit_cnt <= 6'd0;
    end else if (r_state == ST_WAIT && RX_Done_Sig) begin
      r_frame   <= RX_Data;
      r_bit_cnt <= 6'd0;
    end else if (r_state == ST_CRC && r_bit_cnt != CRC_LAST_BIT) begin
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // CRC and address verdicts captured during CHECK
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_crc_ok  <= 1'b0;
      r_addr_ok <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_crc_ok  <= (w_crc == {frame_byte(r_frame, BYTE_CRC_HI),
                              frame_byte(r_frame, BYTE_CRC_LO)});
      r_addr_ok <= (w_addr_byte == SLAVE_ADDR) || (w_addr_byte == 8'h00);
    end else begin
      r_crc_ok  <= r_crc_ok;
      r_addr_ok <= r_addr_ok;
    end
  end

  // Error code assembled from the stored verdicts
  always_comb begin
    w_err_code               = 2'b00;
    w_err_code[ERR_CRC_BIT]  = ~r_crc_ok;
    w_err_code[ERR_ADDR_BIT] = ~r_addr_ok;
  end

  // Registered outputs: enables follow the next state, results load in REPORT
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_err_code  <= 2'b00;
      r_func_code <= 8'h00;
      r_payload   <= 24'h000000;
      r_err_cnt   <= 8'h00;
    end else begin
      r_rx_en <= (w_next_state == ST_WAIT);
      r_busy  <= (w_next_state == ST_CRC) || (w_next_state == ST_CHECK) ||
                 (w_next_state == ST_REPORT);
      r_done  <= (r_state == ST_REPORT);
      if (r_state == ST_REPORT) begin
        r_frame_ok <= r_crc_ok & r_addr_ok;
        r_err_code <= w_err_code;
        if (r_crc_ok && r_addr_ok) begin
          r_func_code <= frame_byte(r_frame, BYTE_FUNC);
          r_payload   <= {frame_byte(r_frame, BYTE_PL0),
                          frame_byte(r_frame, BYTE_PL0 + 1),
                          frame_byte(r_frame, BYTE_PL0 + 2)};
          r_err_cnt   <= r_err_cnt;
        end else begin
          r_func_code <= r_func_code;
          r_payload   <= r_payload;
          r_err_cnt   <= (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
        end
      end else begin
        r_frame_ok  <= r_frame_ok;
        r_err_code  <= r_err_code;
        r_func_code <= r_func_code;
        r_payload   <= r_payload;
        r_err_cnt   <= r_err_cnt;
      end
    end
  end

  assign RX_En_Sig = r_rx_en;
  assign Busy_Sig  = r_busy;
  assign Done_Sig  = r_done;
  assign Frame_OK  = r_frame_ok;
  assign Err_Code  = r_err_code;
  assign Func_Code = r_func_code;
  assign Payload   = r_payload;
  assign Err_Cnt   = r_err_cnt;

endmodule

// File: tb/tb_modbus_frame_check_module.sv
// Directed testbench for modbus_frame_check_module.
module tb_modbus_frame_check_module;

  localparam logic [55:0] GOOD_F = 56'h01_03_00_00_00_19_84;
  localparam logic [55:0] BAD_F  = 56'h01_03_00_00_00_19_85;

  logic        clk;
  logic        rst;
  logic [55:0] rx_data;
  logic        rx_done1, rx_done2;

  logic        rx_en1, busy1, done1, ok1;
  logic [1:0]  err1;
  logic [7:0]  fc1, ec1;
  logic [23:0] pl1;

  logic        rx_en2, busy2, done2, ok2;
  logic [1:0]  err2;
  logic [7:0]  fc2, ec2;
  logic [23:0] pl2;

  int n_tests = 0;
  int n_fail  = 0;

  modbus_frame_check_module #(.SLAVE_ADDR(8'h01)) dut (
    .CLK(clk), .RST(rst), .RX_Done_Sig(rx_done1), .RX_Data(rx_data),
    .RX_En_Sig(rx_en1), .Busy_Sig(busy1), .Done_Sig(done1), .Frame_OK(ok1),
    .Err_Code(err1), .Func_Code(fc1), .Payload(pl1), .Err_Cnt(ec1)
  );

  modbus_frame_check_module #(.SLAVE_ADDR(8'h02)) dut2 (
    .CLK(clk), .RST(rst), .RX_Done_Sig(rx_done2), .RX_Data(rx_data),
    .RX_En_Sig(rx_en2), .Busy_Sig(busy2), .Done_Sig(done2), .Frame_OK(ok2),
    .Err_Code(err2), .Func_Code(fc2), .Payload(pl2), .Err_Cnt(ec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sends one frame to dut (sel=0) or dut2 (sel=1); returns the number of
  // cycles from the sampling edge to Done_Sig (-1 if it never came) and the
  // outputs seen with Done_Sig. Leaves the caller at the Done_Sig negedge.
  task automatic run_frame(input bit sel, input logic [55:0] data,
                           output int lat, output logic ok, output logic [1:0] err,
                           output logic [7:0] fc, output logic [23:0] pl,
                           output logic [7:0] ec);
    int n;
    n = 0;
    while (((sel ? rx_en2 : rx_en1) !== 1'b1) && n < 10) begin
      @(negedge clk);
      n++;
    end
    rx_data = data;
    if (sel) rx_done2 = 1'b1; else rx_done1 = 1'b1;
    @(negedge clk);
    rx_done1 = 1'b0;
    rx_done2 = 1'b0;
    lat = -1;
    ok = 1'bx; err = 2'bxx; fc = 8'hxx; pl = 24'hxxxxxx; ec = 8'hxx;
    for (int i = 1; i <= 100; i++) begin
      if ((sel ? done2 : done1) === 1'b1) begin
        lat = i - 1;
        ok  = sel ? ok2  : ok1;
        err = sel ? err2 : err1;
        fc  = sel ? fc2  : fc1;
        pl  = sel ? pl2  : pl1;
        ec  = sel ? ec2  : ec1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (rx_en1 !== 1'b0) begin n_fail++; $display("FAIL reset_rx_en: got %b want 0", rx_en1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done1); end
    n_tests++; if ({ok1, err1} !== 3'b000) begin n_fail++; $display("FAIL reset_ok_err: got %b want 000", {ok1, err1}); end
    n_tests++; if ({fc1, pl1, ec1} !== 40'd0) begin n_fail++; $display("FAIL reset_fc_pl_ec: got %h want 0", {fc1, pl1, ec1}); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (rx_en1 !== 1'b1) begin n_fail++; $display("FAIL release_rx_en: got %b want 1", rx_en1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b want 0", busy1); end
  endtask

  task automatic test_good_frame();
    int lat; logic ok; logic [1:0] err; logic [7:0] fc, ec; logic [23:0] pl;
    run_frame(1'b0, GOOD_F, lat, ok, err, fc, pl, ec);
    n_tests++; if (lat !== 42) begin n_fail++; $display("FAIL good_latency: got %0d want 42", lat); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL good_ok: got %b want 1", ok); end
    n_tests++; if (err !== 2'b00) begin n_fail++; $display("FAIL good_err: got %b want 00", err); end
    n_tests++; if (fc !== 8'h03) begin n_fail++; $display("FAIL good_func: got %h want 03", fc); end
    n_tests++; if (pl !== 24'h000000) begin n_fail++; $display("FAIL good_payload: got %h want 000000", pl); end
    n_tests++; if (ec !== 8'h00) begin n_fail++; $display("FAIL good_errcnt: got %h want 00", ec); end
    @(negedge clk);
    n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL good_strobe_len: got %b want 0", done1); end
  endtask

  task automatic test_crc_error();
    int lat; logic ok; logic [1:0] err; logic [7:0] fc, ec; logic [23:0] pl;
    run_frame(1'b0, BAD_F, lat, ok, err, fc, pl, ec);
    n_tests++; if (lat !== 42) begin n_fail++; $display("FAIL crc_latency: got %0d want 42", lat); end
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL crc_ok: got %b want 0", ok); end
    n_tests++; if (err !== 2'b01) begin n_fail++; $display("FAIL crc_err: got %b want 01", err); end
    n_tests++; if (ec !== 8'h01) begin n_fail++; $display("FAIL crc_errcnt: got %h want 01", ec); end
    n_tests++; if ({fc, pl} !== 32'h03_000000) begin n_fail++; $display("FAIL crc_hold_fc_pl: got %h want 03000000", {fc, pl}); end
  endtask

  task automatic test_addr_mismatch();
    int lat; logic ok; logic [1:0] err; logic [7:0] fc, ec; logic [23:0] pl;
    run_frame(1'b1, GOOD_F, lat, ok, err, fc, pl, ec);
    n_tests++; if (lat !== 42) begin n_fail++; $display("FAIL addr_latency: got %0d want 42", lat); end
    n_tests++; if ({ok, err} !== 3'b0_10) begin n_fail++; $display("FAIL addr_ok_err: got %b want 010", {ok, err}); end
    n_tests++; if ({fc, ec} !== 16'h00_01) begin n_fail++; $display("FAIL addr_fc_errcnt: got %h want 0001", {fc, ec}); end
    run_frame(1'b1, BAD_F, lat, ok, err, fc, pl, ec);
    n_tests++; if ({ok, err} !== 3'b0_11) begin n_fail++; $display("FAIL both_ok_err: got %b want 011", {ok, err}); end
    n_tests++; if (ec !== 8'h02) begin n_fail++; $display("FAIL both_errcnt: got %h want 02", ec); end
  endtask

  task automatic test_back_to_back();
    int n_done, done_at, rx_en_bad, busy_bad;
    logic ok_seen;
    logic [7:0] ec_seen;
    n_done = 0; done_at = -1; rx_en_bad = 0; busy_bad = 0;
    ok_seen = 1'bx; ec_seen = 8'hxx;
    rx_data  = GOOD_F;
    rx_done1 = 1'b1;
    @(negedge clk);
    rx_done1 = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      if (i == 10) begin rx_data = BAD_F; rx_done1 = 1'b1; end
      if (i == 11) begin rx_done1 = 1'b0; rx_data = GOOD_F; end
      if (done1 === 1'b1) begin
        n_done++;
        done_at = i - 1;
        ok_seen = ok1;
        ec_seen = ec1;
      end
      if (i <= 42 && rx_en1 !== 1'b0) rx_en_bad++;
      if (i <= 42 && busy1 !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", n_done); end
    n_tests++; if (done_at !== 42) begin n_fail++; $display("FAIL b2b_latency: got %0d want 42", done_at); end
    n_tests++; if ({ok_seen, ec_seen} !== 9'h1_01) begin n_fail++; $display("FAIL b2b_ok_errcnt: got %h want 101", {ok_seen, ec_seen}); end
    n_tests++; if (rx_en_bad !== 0) begin n_fail++; $display("FAIL b2b_rx_en_low: got %0d high cycles want 0", rx_en_bad); end
    n_tests++; if (busy_bad !== 0) begin n_fail++; $display("FAIL b2b_busy_high: got %0d low cycles want 0", busy_bad); end
  endtask

  task automatic test_reset_mid_crc();
    int n_done;
    n_done = 0;
    rx_data  = GOOD_F;
    rx_done1 = 1'b1;
    @(negedge clk);
    rx_done1 = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if ({rx_en1, busy1, done1, ok1, err1} !== 6'd0) begin n_fail++; $display("FAIL midrst_ctrl: got %b want 000000", {rx_en1, busy1, done1, ok1, err1}); end
    n_tests++; if ({fc1, pl1, ec1} !== 40'd0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", {fc1, pl1, ec1}); end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (rx_en1 !== 1'b1) begin n_fail++; $display("FAIL midrst_rx_en_back: got %b want 1", rx_en1); end
    for (int i = 0; i < 60; i++) begin
      if (done1 === 1'b1) n_done++;
      @(negedge clk);
    end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", n_done); end
  endtask

  task automatic test_err_saturation();
    int lat, lat_bad; logic ok; logic [1:0] err; logic [7:0] fc, ec; logic [23:0] pl;
    lat_bad = 0;
    for (int k = 1; k <= 256; k++) begin
      run_frame(1'b0, BAD_F, lat, ok, err, fc, pl, ec);
      if (lat != 42) lat_bad++;
      if (k == 254) begin
        n_tests++; if (ec !== 8'hFE) begin n_fail++; $display("FAIL sat_254: got %h want FE", ec); end
      end
      if (k == 255) begin
        n_tests++; if (ec !== 8'hFF) begin n_fail++; $display("FAIL sat_255: got %h want FF", ec); end
      end
    end
    n_tests++; if (ec !== 8'hFF) begin n_fail++; $display("FAIL sat_256: got %h want FF", ec); end
    n_tests++; if (lat_bad !== 0) begin n_fail++; $display("FAIL sat_latency: got %0d late frames want 0", lat_bad); end
    run_frame(1'b0, GOOD_F, lat, ok, err, fc, pl, ec);
    n_tests++; if ({ok, ec} !== 9'h1_FF) begin n_fail++; $display("FAIL sat_hold_after_good: got %h want 1FF", {ok, ec}); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 56'd0;
    rx_done1 = 1'b0;
    rx_done2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_crc_error();
    test_addr_mismatch();
    test_back_to_back();
    test_reset_mid_crc();
    test_err_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
